mmio_port_responder: RTL and testbench
======================================

Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor data-memory bus (Address / WriteData / MemWrite / MemRead / ReadData). It is the target side of the load/store path.
- Owns the 32-bit output port register and a synchronized 8-bit input port with sticky change detection.
- Provides a 32-bit free-running timer with compare-match.
- The top level uses `Hit` to select between this block's `ReadData` and the RAM read data.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte base address of the 32-byte register window; must be 32-byte aligned.
- IN_WIDTH, 8, width of PortIn.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Address  input  32  byte address from the ALU result.
- WriteData  input  32  store data.
- MemWrite  input  1  store strobe; qualified by Hit.
- MemRead  input  1  load strobe; qualified by Hit.
- ReadData  output  32  load data; combinational from registered state.
- Hit  output  1  Address[31:5] == BASE_ADDR[31:5].
- PortIn  input  IN_WIDTH  external asynchronous input.
- PortOut  output  32  output port register.

Behaviour:
- Register map (offset = Address[4:2]; Address[1:0] ignored; word access only):
  - 0 PORT_OUT: RW.
  - 1 PORT_IN: RO, zero-extended synchronized input.
  - 2 STATUS: RO, clear-on-read. Bit0 = CHG (input changed), bit1 = MATCH (timer compare).
  - 3 TIMER_CNT: RW.
  - 4 TIMER_CMP: RW.
  - 5 CTRL: RW. Bit0 = EN, bit1 = AUTOCLR, bits3:2 = IRQ mask (see Optional Feature). Other bits read 0.
  - 6, 7: reserved. Read 0; writes ignored.
- Reset values (reset low, asynchronous):
  - PORT_OUT, TIMER_CNT, CTRL, STATUS = 0.
  - TIMER_CMP = 32'hFFFF_FFFF.
  - Both synchronizer stages = 0.
  - PortOut = 0.
  - ReadData follows the register state, so it reads 0 / the reset values.
- Write: when Hit & MemWrite, the addressed RW register takes WriteData at the clock edge. Write latency is 1 cycle.
- Read:
  - ReadData is valid in the same cycle when Hit & MemRead, which suits the single-cycle core.
  - ReadData = 0 when !(Hit & MemRead).
- Input synchronizer:
  - PortIn passes through 2 flops (sync1 → sync2) plus a prev flop.
  - CHG sets when sync2 != prev.
  - A PortIn change is visible in PORT_IN 2 edges later; CHG sets on the 3rd edge.
- STATUS clear-on-read: the bits read are cleared at the edge ending a Hit & MemRead access to offset 2.
  - If a set event occurs on the same edge, the set wins and the bit stays 1.
- Timer:
  - When EN = 1, TIMER_CNT increments by 1 per clock and wraps from FFFF_FFFF to 0.
  - MATCH sets on the edge where the pre-increment count == TIMER_CMP.
  - If AUTOCLR = 1, that same edge loads 0 instead of count+1.
  - A software write to TIMER_CNT overrides the increment on that edge.
  - When EN = 0, the count holds.
- Simultaneous MemRead and MemWrite to the same offset: the write is applied and ReadData shows the old value.
- A mid-operation reset assertion immediately forces all reset values. No in-flight state survives.

Optional Feature:
- Macro MMIO_IRQ_EN.
- When defined:
  - Adds output port `irq` (1 bit): irq = (CHG & CTRL[2]) | (MATCH & CTRL[3]).
  - irq is registered, reset 0, and follows STATUS/CTRL with 1 cycle latency.
  - irq deasserts the cycle after the STATUS clear-on-read.
- When undefined:
  - No `irq` port.
  - CTRL[3:2] are not stored and read 0.

Test Plan:
- Reset low, PortIn = 8'hA5 → PortOut = 0; a read at offset 0x14 (CTRL) gives 0; a read at offset 0x10 (TIMER_CMP) gives FFFF_FFFF; Hit = 1 for 0x1001_0000 and Hit = 0 for 0x1001_0020.
- Write 32'hDEAD_BEEF to 0x1001_0000 → PortOut = DEAD_BEEF after 1 edge; read-back matches; a write to 0x1001_0018 is ignored and reads 0.
- PortIn changes 00 → 3C → PORT_IN reads 0000_003C after 2 edges; STATUS = 1 after 3 edges; STATUS reads 0 on the next read; a change on the read edge keeps CHG = 1.
- TIMER_CMP = 5, CTRL = 3 → count sequence 0,1,2,3,4,5,0; MATCH set; STATUS read gives 2 then 0.
- TIMER_CNT = FFFF_FFFE, CTRL = 1, CMP = 3 → count goes FFFF_FFFF, 0, 1 (wrap); a write of 100 to TIMER_CNT mid-count loads 100 and the next cycle reads 101.
- With MMIO_IRQ_EN: CTRL = 4'b0101, PortIn toggles → irq = 1 one cycle after CHG sets; STATUS read → irq = 0 one cycle after the clear; reset asserted mid-count → irq and count go to 0 immediately.

Source files
------------

// File: rtl/mmio_port_responder.sv
// Memory-mapped responder: output port, synchronized input port with sticky change flag, timer with compare.
// Optional MMIO_IRQ_EN adds a registered irq output driven by the CTRL[3:2] mask over STATUS.
module mmio_port_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
   parameter int          IN_WIDTH  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         Address,
   input  logic [31:0]         WriteData,
   input  logic                MemWrite,
   input  logic                MemRead,
   output logic [31:0]         ReadData,
   output logic                Hit,
   input  logic [IN_WIDTH-1:0] PortIn,
   output logic [31:0]         PortOut
`ifdef MMIO_IRQ_EN
   ,
   output logic                irq
`endif
);

   typedef enum logic [2:0] {
      OFF_PORT_OUT  = 3'd0,
      OFF_PORT_IN   = 3'd1,
      OFF_STATUS    = 3'd2,
      OFF_TIMER_CNT = 3'd3,
      OFF_TIMER_CMP = 3'd4,
      OFF_CTRL      = 3'd5,
      OFF_RSVD6     = 3'd6,
      OFF_RSVD7     = 3'd7
   } reg_off_e;

`ifdef MMIO_IRQ_EN
   localparam int CTRL_W = 4;
`else
   localparam int CTRL_W = 2;
`endif

   logic [31:0]         r_port_out;
   logic [31:0]         r_timer_cnt;
   logic [31:0]         r_timer_cmp;
   logic [CTRL_W-1:0]   r_ctrl;
   logic [1:0]          r_status;
   logic [IN_WIDTH-1:0] r_sync1, r_sync2, r_prev;

   reg_off_e    w_off;
   logic        w_hit, w_wr, w_rd, w_clr;
   logic        w_chg_evt, w_match_evt;
   logic [1:0]  w_status_nxt;
   logic        w_unused;

   assign w_off    = reg_off_e'(Address[4:2]);
   assign w_hit    = (Address[31:5] == BASE_ADDR[31:5]);
   assign w_wr     = w_hit & MemWrite;
   assign w_rd     = w_hit & MemRead;
   assign w_unused = &{1'b0, Address[1:0]};

   assign w_chg_evt   = (r_sync2 != r_prev);
   assign w_match_evt = r_ctrl[0] && (r_timer_cnt == r_timer_cmp);

   // A set event on the clearing edge wins: clear first, then OR in the new events.
   assign w_clr        = w_rd && (w_off == OFF_STATUS);
   assign w_status_nxt = (r_status & ~{2{w_clr}}) | {w_match_evt, w_chg_evt};

   assign Hit     = w_hit;
   assign PortOut = r_port_out;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_port_out  <= '0;
         r_timer_cnt <= '0;
         r_timer_cmp <= '1;
         r_ctrl      <= '0;
         r_status    <= '0;
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_prev      <= '0;
      end else begin
         r_sync1  <= PortIn;
         r_sync2  <= r_sync1;
         r_prev   <= r_sync2;
         r_status <= w_status_nxt;

         if (w_wr && w_off == OFF_PORT_OUT)  r_port_out  <= WriteData;
         if (w_wr && w_off == OFF_TIMER_CMP) r_timer_cmp <= WriteData;
         if (w_wr && w_off == OFF_CTRL)      r_ctrl      <= WriteData[CTRL_W-1:0];

         if (w_wr && w_off == OFF_TIMER_CNT)
            r_timer_cnt <= WriteData;
         else if (r_ctrl[0]) begin
            if (w_match_evt && r_ctrl[1]) r_timer_cnt <= '0;
            else                          r_timer_cnt <= r_timer_cnt + 32'd1;
         end
      end
   end

`ifdef MMIO_IRQ_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) irq <= 1'b0;
      else        irq <= (r_status[0] & r_ctrl[2]) | (r_status[1] & r_ctrl[3]);
   end
`endif

   // NOTE: ReadData gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      ReadData = '0;
      if (w_rd) begin
         case (w_off)
            OFF_PORT_OUT:  ReadData = r_port_out;
            OFF_PORT_IN:   ReadData = 32'(r_sync2);
            OFF_STATUS:    ReadData = {30'd0, r_status};
            OFF_TIMER_CNT: ReadData = r_timer_cnt;
            OFF_TIMER_CMP: ReadData = r_timer_cmp;
            OFF_CTRL:      ReadData = 32'(r_ctrl);
            default:       ReadData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder: expected read data is queued when a load is issued
// and popped when the combinational ReadData is sampled. Define MMIO_IRQ_EN to cover irq.
module tb_mmio_port_responder;

   localparam logic [31:0] BASE     = 32'h1001_0000;
   localparam logic [31:0] A_OUT    = BASE + 32'h00;
   localparam logic [31:0] A_IN     = BASE + 32'h04;
   localparam logic [31:0] A_STATUS = BASE + 32'h08;
   localparam logic [31:0] A_CNT    = BASE + 32'h0C;
   localparam logic [31:0] A_CMP    = BASE + 32'h10;
   localparam logic [31:0] A_CTRL   = BASE + 32'h14;
   localparam logic [31:0] A_RSVD   = BASE + 32'h18;
`ifdef MMIO_IRQ_EN
   localparam logic [31:0] CTRL_ALL = 32'h0000_000F;
`else
   localparam logic [31:0] CTRL_ALL = 32'h0000_0003;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address, WriteData, ReadData, PortOut;
   logic        MemWrite, MemRead, Hit;
   logic [7:0]  PortIn;
`ifdef MMIO_IRQ_EN
   logic        irq;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];

   mmio_port_responder #(.BASE_ADDR(BASE), .IN_WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .Address   (Address),
      .WriteData (WriteData),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .ReadData  (ReadData),
      .Hit       (Hit),
      .PortIn    (PortIn),
      .PortOut   (PortOut)
`ifdef MMIO_IRQ_EN
      ,
      .irq       (irq)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pop the oldest expected load value and compare it with ReadData now.
   task automatic sb_check(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed=empty-queue expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk(tag, ReadData, e);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      Address   = addr;
      WriteData = data;
      MemWrite  = 1'b1;
      MemRead   = 1'b0;
      tick();
      MemWrite  = 1'b0;
   endtask

   // One load: sampled at the falling edge, the access ends at the next rising edge.
   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      Address  = addr;
      MemRead  = 1'b1;
      MemWrite = 1'b0;
      exp_q.push_back(exp);
      @(negedge clk);
      sb_check(tag);
      tick();
      MemRead = 1'b0;
   endtask

   initial begin
      reset = 1'b0; Address = '0; WriteData = '0;
      MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'hA5;

      // Reset state
      tick();
      chk("rst_portout", PortOut, 32'h0);
      rd(A_CTRL,   32'h0,         "rst_ctrl");
      rd(A_CMP,    32'hFFFF_FFFF, "rst_cmp");
      rd(A_STATUS, 32'h0,         "rst_status");
      Address = BASE;               #1 chk("hit_base", 32'(Hit), 32'h1);
      Address = BASE + 32'h20;      #1 chk("hit_above", 32'(Hit), 32'h0);
      reset = 1'b1;

      // Output port, reserved slot, idle bus
      wr(A_OUT, 32'hDEAD_BEEF);
      chk("portout_wr", PortOut, 32'hDEAD_BEEF);
      rd(A_OUT,  32'hDEAD_BEEF, "portout_rd");
      wr(A_RSVD, 32'h1234_5678);
      rd(A_RSVD, 32'h0,         "rsvd_rd");
      rd(A_IN,   32'h0000_00A5, "portin_a5");
      Address = A_OUT; MemRead = 1'b0; #1 chk("idle_rd_zero", ReadData, 32'h0);

      // Input synchronizer and sticky CHG with clear-on-read
      PortIn = 8'h00;
      repeat (4) tick();
      rd(A_STATUS, 32'h1, "chg_initial");
      rd(A_STATUS, 32'h0, "chg_cleared");
      PortIn = 8'h3C;
      tick();
      rd(A_IN,     32'h0,         "portin_1edge");
      rd(A_IN,     32'h0000_003C, "portin_2edge");
      rd(A_STATUS, 32'h1,         "chg_3edge");
      rd(A_STATUS, 32'h0,         "chg_clr");
      PortIn = 8'h81;
      tick();
      PortIn = 8'h18;
      tick();
      tick();
      rd(A_STATUS, 32'h1, "chg_set_on_rd_edge");
      rd(A_STATUS, 32'h1, "chg_kept");
      rd(A_STATUS, 32'h0, "chg_final_clr");

      // Timer compare with auto-clear
      wr(A_CMP, 32'd5);
      wr(A_CNT, 32'd0);
      wr(A_CTRL, 32'd3);
      for (int i = 0; i <= 5; i++) rd(A_CNT, 32'(i), $sformatf("cnt_%0d", i));
      rd(A_CNT,    32'd0, "cnt_autoclr");
      rd(A_STATUS, 32'h2, "match_set");
      rd(A_STATUS, 32'h0, "match_clr");

      // Wrap-around and software override of the count
      wr(A_CTRL, 32'd0);
      wr(A_CMP,  32'd3);
      wr(A_CNT,  32'hFFFF_FFFE);
      wr(A_CTRL, 32'd1);
      rd(A_CNT, 32'hFFFF_FFFE, "wrap_fffe");
      rd(A_CNT, 32'hFFFF_FFFF, "wrap_ffff");
      rd(A_CNT, 32'h0,         "wrap_0");
      rd(A_CNT, 32'h1,         "wrap_1");
      wr(A_CNT, 32'd100);
      rd(A_CNT, 32'd100, "cnt_sw_load");
      rd(A_CNT, 32'd101, "cnt_sw_next");

      // Same-cycle load and store: old value read, new value stored
      Address = A_OUT; WriteData = 32'h1234_5678; MemWrite = 1'b1; MemRead = 1'b1;
      exp_q.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      sb_check("rw_same_old");
      tick();
      MemWrite = 1'b0; MemRead = 1'b0;
      chk("rw_same_new", PortOut, 32'h1234_5678);

`ifdef MMIO_IRQ_EN
      // irq from CHG mask, cleared one cycle after the status clear
      wr(A_CTRL, 32'h5);
      chk("irq_idle", 32'(irq), 32'h0);
      PortIn = 8'h55;
      repeat (3) tick();
      chk("irq_not_yet", 32'(irq), 32'h0);
      tick();
      chk("irq_set", 32'(irq), 32'h1);
      rd(A_STATUS, 32'h1, "irq_status");
      chk("irq_hold", 32'(irq), 32'h1);
      tick();
      chk("irq_clr", 32'(irq), 32'h0);
      PortIn = 8'hAA;
      repeat (4) tick();
`endif

      // Asynchronous reset in the middle of a running count
      @(negedge clk);
      #2;
      reset = 1'b0;
      Address = A_CNT; MemRead = 1'b1;
      exp_q.push_back(32'h0);
      #1;
      sb_check("midrst_cnt");
      chk("midrst_portout", PortOut, 32'h0);
`ifdef MMIO_IRQ_EN
      chk("midrst_irq", 32'(irq), 32'h0);
`endif
      MemRead = 1'b0;
      tick();
      reset = 1'b1;
      rd(A_OUT, 32'h0, "post_rst_out");
      wr(A_CTRL, 32'hFFFF_FFFF);
      rd(A_CTRL, CTRL_ALL, "ctrl_bits");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
